instr_word_loader: RTL and testbench

//  Builds 32-bit MIPS-style instruction words from decoded fields and writes them
//  big-endian, one byte per cycle, into the byte-wide instruction memory of the

---
 rtl/instr_word_loader.sv | 158 +++++++++++++++
 tb/tb_instr_word_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_word_loader.sv
// Instruction word loader: packs decoded MIPS-style fields into a 32-bit word
// and writes it big-endian, one byte per cycle, into byte-wide instruction
// memory. Successive words land at consecutive word addresses from BASE_ADDR.
//
// Ports:
//   CLK        clock, rising edge
//   Reset      asynchronous active-low reset
//   clear      synchronous abort; zeroes the word count
//   in_valid   field set present
//   in_ready   loader can accept a field set (registered)
//   fmt_r      1: R-format low half {rd,sa,immediate[5:0]}; 0: I-format immediate
//   op/rs/rt/rd/sa/immediate   decoded instruction fields
//   mem_we     byte write enable to instruction memory
//   mem_addr   byte address
//   mem_wdata  byte data
//   word_count number of complete words written
//   full       word_count == MAX_WORDS
//   word_done  one-cycle pulse while the last byte of a word is written
module instr_word_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fmt_r,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        sa,
  input  logic [15:0]       immediate,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-2:0] word_count,
  output logic              full,
  output logic              word_done
);

  localparam int unsigned CNT_W  = ADDR_W - 1;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   word_q, word_n;
  logic [WORD_W-1:0]   new_word_c;
  logic [CNT_W-1:0]    count_n;
  logic                full_n;
  logic                ready_n;
  logic                we_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [7:0]          wdata_n;
  logic                done_n;
  logic                accept_c;

  // Word layout follows the instruction register field split.
  always_comb begin
    if (fmt_r) begin
      new_word_c = {op, rs, rt, rd, sa, immediate[5:0]};
    end else begin
      new_word_c = {op, rs, rt, immediate};
    end
  end

  // in_ready is only ever high in IDLE with room left.
  assign accept_c = in_valid && in_ready && (state == IDLE);

  // Next state and next registered outputs. Outputs are computed one cycle
  // ahead so that while the FSM sits in Bk the bus presents byte k.
  always_comb begin
    state_n = state;
    word_n  = word_q;
    count_n = word_count;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    done_n  = 1'b0;

    if (clear) begin
      // Abort: whatever bytes were already written stay in memory.
      state_n = IDLE;
      count_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            state_n = B0;
            word_n  = new_word_c;
            we_n    = 1'b1;
            addr_n  = ADDR_W'(BASE_ADDR) + ADDR_W'({word_count, 2'b00});
            wdata_n = new_word_c[31:24];
          end
        end
        B0: begin
          state_n = B1;
          we_n    = 1'b1;
          addr_n  = mem_addr + ADDR_W'(1);
          wdata_n = word_q[23:16];
        end
        B1: begin
          state_n = B2;
          we_n    = 1'b1;
          addr_n  = mem_addr + ADDR_W'(1);
          wdata_n = word_q[15:8];
        end
        B2: begin
          // Count and done pulse become visible together with the last byte.
          state_n = B3;
          we_n    = 1'b1;
          addr_n  = mem_addr + ADDR_W'(1);
          wdata_n = word_q[7:0];
          count_n = word_count + CNT_W'(1);
          done_n  = 1'b1;
        end
        B3: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    full_n  = (count_n == CNT_W'(MAX_WORDS));
    ready_n = (state_n == IDLE) && !full_n;
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      word_q     <= '0;
      word_count <= '0;
      full       <= 1'b0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_n;
      word_q     <= word_n;
      word_count <= count_n;
      full       <= full_n;
      in_ready   <= ready_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      word_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_instr_word_loader.sv
// Scoreboard bench for instr_word_loader (ADDR_W=8, BASE_ADDR=0, MAX_WORDS=2).
// Stimulus pushes expected byte writes and expected status snapshots into
// queues; a negedge monitor pops and compares them.
module tb_instr_word_loader;

  logic        CLK;
  logic        Reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic        fmt_r;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] immediate;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [6:0]  word_count;
  logic        full;
  logic        word_done;

  instr_word_loader #(
    .ADDR_W   (8),
    .BASE_ADDR(0),
    .MAX_WORDS(2)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt_r     (fmt_r),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .sa        (sa),
    .immediate (immediate),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .word_count(word_count),
    .full      (full),
    .word_done (word_done)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;

  typedef struct {
    string      name;
    logic [6:0] wc;
    logic       full;
    logic       rdy;
    logic       we;
    logic       done;
  } stat_t;

  wr_t   exp_q[$];
  stat_t stat_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  finish_req = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: compares byte writes and status snapshots away from the active edge.
  always @(negedge CLK) begin
    wr_t   w;
    stat_t s;
    while (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      checks++;
      if (word_count !== s.wc || full !== s.full || in_ready !== s.rdy ||
          mem_we !== s.we || word_done !== s.done) begin
        errors++;
        $display("FAIL %s: got wc=%0d full=%b rdy=%b we=%b done=%b, want wc=%0d full=%b rdy=%b we=%b done=%b",
                 s.name, word_count, full, in_ready, mem_we, word_done,
                 s.wc, s.full, s.rdy, s.we, s.done);
      end
    end
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h done=%b, want no write",
                 mem_addr, mem_wdata, word_done);
      end else begin
        w = exp_q.pop_front();
        if (mem_addr !== w.addr || mem_wdata !== w.data || word_done !== w.done) begin
          errors++;
          $display("FAIL byte_write: got addr=%h data=%h done=%b, want addr=%h data=%h done=%b",
                   mem_addr, mem_wdata, word_done, w.addr, w.data, w.done);
        end
      end
    end else if (word_done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL done_without_write: got word_done=%b, want 0", word_done);
    end
    if (finish_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_writes: got %0d writes outstanding, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_status(input string name, input int wc, input logic f,
                               input logic r, input logic we, input logic d);
    stat_t s;
    s.name = name;
    s.wc   = 7'(wc);
    s.full = f;
    s.rdy  = r;
    s.we   = we;
    s.done = d;
    stat_q.push_back(s);
  endtask

  task automatic set_fields(input logic f, input logic [5:0] o, input logic [4:0] s_,
                            input logic [4:0] t, input logic [4:0] d, input logic [4:0] a,
                            input logic [15:0] i);
    fmt_r = f; op = o; rs = s_; rt = t; rd = d; sa = a; immediate = i;
  endtask

  task automatic set_random_fields();
    set_fields(1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), 16'($urandom));
  endtask

  // Present a field set for one edge; DUT is expected to be ready.
  task automatic send(input logic f, input logic [5:0] o, input logic [4:0] s_,
                      input logic [4:0] t, input logic [4:0] d, input logic [4:0] a,
                      input logic [15:0] i);
    set_fields(f, o, s_, t, d, a, i);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] base, input logic [31:0] w, input int nbytes);
    wr_t e;
    for (int k = 0; k < nbytes; k++) begin
      e.addr = base + 8'(k);
      e.data = w[31-8*k -: 8];
      e.done = (k == 3);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    Reset = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    set_fields(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0);

    // Reset state
    tick();
    tick();
    expect_status("in_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    tick();
    expect_status("ready_after_release", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a word
    send(1'b0, 6'd1, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0005);
    push_word(8'd0, 32'h0443_0005, 1);
    expect_status("first_b0", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    Reset = 1'b0;
    expect_status("reset_mid_b1", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    expect_status("ready_after_mid_reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // I-format word at addresses 0..3
    send(1'b0, 6'd1, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0005);
    push_word(8'd0, 32'h0443_0005, 4);
    repeat (3) tick();
    expect_status("w1_b3", 1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_status("w1_idle", 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // R-format word at addresses 4..7, fills the loader
    send(1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0000);
    push_word(8'd4, 32'h0022_1900, 4);
    repeat (3) tick();
    expect_status("w2_b3", 2, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    expect_status("full_idle", 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Requests while full are ignored; clear reopens at address 0
    set_fields(1'b0, 6'h3F, 5'd7, 5'd7, 5'd0, 5'd0, 16'hAAAA);
    in_valid = 1'b1;
    repeat (6) tick();
    expect_status("full_ignores", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_status("clear_from_full", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back with in_valid held; fields scrambled while a word is in flight
    set_fields(1'b0, 6'h23, 5'd4, 5'd5, 5'd0, 5'd0, 16'hBEEF);
    in_valid = 1'b1;
    tick();
    push_word(8'd0, 32'h8C85_BEEF, 4);
    expect_status("bb_a_b0", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      set_random_fields();
      tick();
    end
    set_random_fields();
    expect_status("bb_a_b3", 1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    set_fields(1'b1, 6'd0, 5'd31, 5'd0, 5'd31, 5'd31, 16'hFFFF);
    expect_status("bb_gap", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    push_word(8'd4, 32'h03E0_FFFF, 4);
    expect_status("bb_b_b0", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      set_random_fields();
      tick();
    end
    expect_status("bb_b_b3", 2, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    expect_status("bb_full", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    in_valid = 1'b0;

    // clear during B2: no last byte, no done pulse, count back to zero
    clear = 1'b1;
    tick();
    clear = 1'b0;
    send(1'b0, 6'h0F, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234);
    push_word(8'd0, 32'h3C01_1234, 3);
    tick();
    tick();
    clear = 1'b1;
    expect_status("clr_b2", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    clear = 1'b0;
    expect_status("clr_idle", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_status("no_b3", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    tick();
    finish_req = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor_stall: summary not reached, want monitor to finish");
    $fatal(1);
  end

endmodule
